// File: rtl/pll_recfg_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// pll_recfg_ctrl_pkg : shared types and constants for the PLL reconfig block
// Revision: 1.0
// ============================================================================
package pll_recfg_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        GAP  = 3'd2,
        PRST = 3'd3,
        LOCK = 3'd4,
        FIN  = 3'd5
    } state_t;

    localparam logic [5:0] ADDR_MODE  = 6'd0;
    localparam logic [5:0] ADDR_M     = 6'd4;
    localparam logic [5:0] ADDR_K     = 6'd7;
    localparam logic [5:0] ADDR_N     = 6'd3;
    localparam logic [5:0] ADDR_C     = 6'd5;
    localparam logic [5:0] ADDR_CP    = 6'd9;
    localparam logic [5:0] ADDR_BW    = 6'd8;
    localparam logic [5:0] ADDR_START = 6'd2;

    localparam logic [31:0] N_COUNT    = 32'h0001_0000;
    localparam logic [31:0] CP_SETTING = 32'd1;
    localparam logic [31:0] BW_SETTING = 32'd7;

    typedef struct packed {
        logic [11:0] freq_bcd;
        logic [31:0] m;
        logic [31:0] k;
        logic [31:0] c0;
    } preset_t;

    function automatic logic [5:0] slot_addr(input logic [2:0] slot);
        case (slot)
            3'd0:    slot_addr = ADDR_MODE;
            3'd1:    slot_addr = ADDR_M;
            3'd2:    slot_addr = ADDR_K;
            3'd3:    slot_addr = ADDR_N;
            3'd4:    slot_addr = ADDR_C;
            3'd5:    slot_addr = ADDR_CP;
            3'd6:    slot_addr = ADDR_BW;
            default: slot_addr = ADDR_START;
        endcase
    endfunction

    // Slots 0 (mode) and 7 (start) always carry zero.
    function automatic logic [31:0] slot_data(input logic [2:0] slot, input logic [31:0] m,
                                              input logic [31:0] k, input logic [31:0] c0);
        case (slot)
            3'd1:    slot_data = m;
            3'd2:    slot_data = k;
            3'd3:    slot_data = N_COUNT;
            3'd4:    slot_data = c0;
            3'd5:    slot_data = CP_SETTING;
            3'd6:    slot_data = BW_SETTING;
            default: slot_data = 32'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/pll_recfg_ctrl_rom.sv
`default_nettype none
// ============================================================================
// pll_preset_rom : combinational table of PLL presets indexed by 6 bits
// Revision: 1.0
// ============================================================================
module pll_preset_rom
    import pll_recfg_ctrl_pkg::*;
(
    input  logic [5:0] idx,
    output preset_t    entry
);

    logic [9:0] mhz;
    logic [7:0] cdiv;
    logic [7:0] mdiv;

    // Intermediate entries step the output 2 MHz per index from 100 MHz.
    always_comb begin
        mhz   = 10'd100 + {3'd0, idx, 1'b0};
        cdiv  = {2'b00, idx} + 8'd2;
        mdiv  = 8'd8 + {5'd0, idx[5:3]};
        entry = '0;
        case (idx)
            6'd0: begin
                entry.freq_bcd = 12'h167;
                entry.m        = 32'h0000_0808;
                entry.k        = 32'hB333_32DD;
                entry.c0       = 32'h0002_0302;
            end
            6'd37: begin
                entry.freq_bcd = 12'h070;
                entry.m        = 32'h0000_0707;
                entry.k        = 32'h0000_0001;
                entry.c0       = 32'h0000_0505;
            end
            default: begin
                if (idx < 6'd37) begin
                    entry.freq_bcd = {4'(mhz / 10'd100), 4'((mhz / 10'd10) % 10'd10), 4'(mhz % 10'd10)};
                    entry.m        = {16'h0000, mdiv, mdiv};
                    entry.k        = {2'b00, idx, 24'h00_0000};
                    entry.c0       = {14'h0000, 2'b10, cdiv, cdiv};
                end
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pll_recfg_ctrl.sv
`default_nettype none
// ============================================================================
// pll_recfg_ctrl : writes a PLL preset over Avalon-MM, resets PLL, waits lock
// Revision: 1.0
// ============================================================================
module pll_recfg_ctrl
    import pll_recfg_ctrl_pkg::*;
#(
    parameter int NUM_PRESETS  = 38,
    parameter int GAP_CYCLES   = 7,
    parameter int RST_CYCLES   = 8,
    parameter int LOCK_STABLE  = 1024,
    parameter int LOCK_TIMEOUT = 5000000
) (
    input  logic        CLK_50M,
    input  logic        RESET,
    input  logic        start,
    input  logic [5:0]  preset_idx,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [11:0] freq_bcd,
    output logic [5:0]  mgmt_address,
    output logic [31:0] mgmt_writedata,
    output logic        mgmt_write,
    input  logic        mgmt_waitrequest,
    input  logic        locked,
    output logic        pll_reset
);

    localparam int              LS_W     = $clog2(LOCK_STABLE + 1);
    localparam logic [LS_W-1:0] LS_LAST  = LS_W'(LOCK_STABLE - 1);
    localparam logic [22:0]     TO_LAST  = 23'(LOCK_TIMEOUT - 1);
    localparam logic [7:0]      GAP_LAST = 8'(GAP_CYCLES - 1);
    localparam logic [7:0]      RST_LAST = 8'(RST_CYCLES - 1);

    state_t          state;
    logic [5:0]      idx_r;
    logic [2:0]      slot;
    logic [7:0]      phase;
    logic [LS_W-1:0] lock_cnt;
    logic [22:0]     to_cnt;
    preset_t         rom_entry;

    pll_preset_rom u_rom (
        .idx   (idx_r),
        .entry (rom_entry)
    );

    always_ff @(posedge CLK_50M) begin
        if (RESET) begin
            state          <= IDLE;
            idx_r          <= '0;
            slot           <= '0;
            phase          <= '0;
            lock_cnt       <= '0;
            to_cnt         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            freq_bcd       <= '0;
            mgmt_address   <= '0;
            mgmt_writedata <= '0;
            mgmt_write     <= 1'b0;
            pll_reset      <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if ({26'd0, preset_idx} >= 32'(NUM_PRESETS)) begin
                            err <= 1'b1;
                        end else begin
                            idx_r          <= preset_idx;
                            busy           <= 1'b1;
                            slot           <= 3'd0;
                            mgmt_write     <= 1'b1;
                            mgmt_address   <= slot_addr(3'd0);
                            mgmt_writedata <= 32'd0;
                            state          <= WR;
                        end
                    end
                end
                WR: begin
                    if (!mgmt_waitrequest) begin
                        mgmt_write <= 1'b0;
                        phase      <= '0;
                        state      <= GAP;
                    end
                end
                GAP: begin
                    if (phase == GAP_LAST) begin
                        phase <= '0;
                        if (slot == 3'd7) begin
                            pll_reset <= 1'b1;
                            state     <= PRST;
                        end else begin
                            slot           <= slot + 3'd1;
                            mgmt_write     <= 1'b1;
                            mgmt_address   <= slot_addr(slot + 3'd1);
                            mgmt_writedata <= slot_data(slot + 3'd1, rom_entry.m, rom_entry.k, rom_entry.c0);
                            state          <= WR;
                        end
                    end else begin
                        phase <= phase + 8'd1;
                    end
                end
                PRST: begin
                    if (phase == RST_LAST) begin
                        pll_reset <= 1'b0;
                        lock_cnt  <= '0;
                        to_cnt    <= '0;
                        state     <= LOCK;
                    end else begin
                        phase <= phase + 8'd1;
                    end
                end
                LOCK: begin
                    // A completed lock window wins over a timeout landing on the same cycle.
                    if (locked && lock_cnt == LS_LAST) begin
                        done     <= 1'b1;
                        freq_bcd <= rom_entry.freq_bcd;
                        state    <= FIN;
                    end else if (to_cnt == TO_LAST) begin
                        err   <= 1'b1;
                        state <= FIN;
                    end else begin
                        lock_cnt <= locked ? lock_cnt + 1'b1 : '0;
                        if (to_cnt != 23'h7F_FFFF) begin
                            to_cnt <= to_cnt + 23'd1;
                        end
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pll_recfg_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pll_recfg_ctrl : scheduled stimulus, timeline model and event scoreboard
// Revision: 1.0
// ============================================================================
module tb_pll_recfg_ctrl;

    localparam int N_PRE  = 38;
    localparam int GAP    = 7;
    localparam int RSTC   = 8;
    localparam int STABLE = 1024;
    localparam int TMO    = 3000;
    localparam int MAXC   = 100000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  preset_idx = '0;
    logic        busy, done, err, mw, prst;
    logic [11:0] freq;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic        waitreq = 1'b0;
    logic        locked = 1'b0;

    pll_recfg_ctrl #(
        .NUM_PRESETS (N_PRE),
        .GAP_CYCLES  (GAP),
        .RST_CYCLES  (RSTC),
        .LOCK_STABLE (STABLE),
        .LOCK_TIMEOUT(TMO)
    ) dut (
        .CLK_50M         (clk),
        .RESET           (rst),
        .start           (start),
        .preset_idx      (preset_idx),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .freq_bcd        (freq),
        .mgmt_address    (addr),
        .mgmt_writedata  (wdata),
        .mgmt_write      (mw),
        .mgmt_waitrequest(waitreq),
        .locked          (locked),
        .pll_reset       (prst)
    );

    always #10 clk = ~clk;

    typedef struct {
        int          kind;   // 0 write accept, 1 done, 2 err
        int          cyc;
        logic [5:0]  addr;
        logic [31:0] data;
    } ev_t;

    ev_t         exp_q[$];
    bit          wr_sched[MAXC];
    bit          lk_sched[MAXC];
    bit          exp_busy[MAXC];
    bit          exp_prst[MAXC];
    bit          exp_mw[MAXC];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [11:0] model_freq = '0;
    int          stall[8];
    int          lock_lat = 0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        waitreq = (cyc < MAXC) ? wr_sched[cyc] : 1'b0;
        locked  = (cyc < MAXC) ? lk_sched[cyc] : 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp_v);
        end
    endtask

    task automatic push_ev(input int kind, input int c, input logic [5:0] a, input logic [31:0] d);
        ev_t e;
        e.kind = kind; e.cyc = c; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    // Preset contents as documented for the table: 0 and 37 fixed, 1..36 step 2 MHz.
    function automatic void ref_preset(input int i, output logic [11:0] f, output logic [31:0] m,
                                       output logic [31:0] k, output logic [31:0] c0);
        int mhz, d, md;
        mhz = 100 + 2 * i; d = i + 2; md = 8 + i / 8;
        if (i == 0) begin
            f = 12'h167; m = 32'h808; k = 32'hB33332DD; c0 = 32'h20302;
        end else if (i == 37) begin
            f = 12'h070; m = 32'h707; k = 32'h1; c0 = 32'h505;
        end else begin
            f  = 12'((mhz / 100) * 256 + ((mhz / 10) % 10) * 16 + mhz % 10);
            m  = 32'(md * 257);
            k  = 32'(i) << 24;
            c0 = 32'h20000 + 32'(d * 257);
        end
    endfunction

    task automatic observe(input int kind, input logic [5:0] a, input logic [31:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_event at cycle %0d: got kind %0d addr %h data %h, expected none", cyc, kind, a, d);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", 32'(kind), 32'(e.kind));
            chk("event_cycle", 32'(cyc), 32'(e.cyc));
            chk("event_addr", {26'd0, a}, {26'd0, e.addr});
            chk("event_data", d, e.data);
        end
    endtask

    logic        prev_mw = 1'b0, prev_acc = 1'b0;
    logic [5:0]  prev_addr = '0;
    logic [31:0] prev_data = '0;

    always @(negedge clk) begin
        if (cyc < MAXC) begin
            chk("busy", 32'(busy), 32'(exp_busy[cyc]));
            chk("pll_reset", 32'(prst), 32'(exp_prst[cyc]));
            chk("mgmt_write", 32'(mw), 32'(exp_mw[cyc]));
        end
        chk("done_err_overlap", 32'(done & err), 32'd0);
        if (mw && prev_mw && !prev_acc) begin
            chk("hold_addr", {26'd0, addr}, {26'd0, prev_addr});
            chk("hold_data", wdata, prev_data);
        end
        if (mw && !waitreq) observe(0, addr, wdata);
        if (done) observe(1, 6'd0, {20'd0, freq});
        if (err)  observe(2, 6'd0, {20'd0, freq});
        prev_mw   = mw;
        prev_acc  = mw && !waitreq;
        prev_addr = addr;
        prev_data = wdata;
    end

    task automatic chk_reset_outputs();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_mgmt_write", 32'(mw), 32'd0);
        chk("rst_addr", {26'd0, addr}, 32'd0);
        chk("rst_data", wdata, 32'd0);
        chk("rst_pll_reset", 32'(prst), 32'd0);
        chk("rst_freq", {20'd0, freq}, 32'd0);
    endtask

    // Issue one start and lay out the whole expected timeline for it.
    // mode: 0 locked from lock_lat, 1 never locked, 2 drop at count 1000, 3 noisy then locked
    task automatic go(input int idx, input int mode, input int xs_slot, input int r_slot);
        int s, F, R, xs, L0, endc, run, isdone;
        int asrt[8], acc[8];
        bit lk[TMO];
        logic [11:0] f;
        logic [31:0] m, k, c0;
        logic [5:0]  adr[8];
        logic [31:0] dat[8];
        s = cyc; R = MAXC - 1; xs = -1;
        preset_idx = 6'(idx);
        start = 1'b1;
        if (idx >= N_PRE) begin
            push_ev(2, s + 1, 6'd0, {20'd0, model_freq});
            endc = s + 2;
        end else begin
            ref_preset(idx, f, m, k, c0);
            adr = '{6'd0, 6'd4, 6'd7, 6'd3, 6'd5, 6'd9, 6'd8, 6'd2};
            dat = '{32'd0, m, k, 32'h10000, c0, 32'd1, 32'd7, 32'd0};
            for (int i = 0; i < 8; i++) begin
                asrt[i] = (i == 0) ? s + 1 : acc[i-1] + GAP + 1;
                acc[i]  = asrt[i] + stall[i];
            end
            L0 = acc[7] + GAP + 1 + RSTC;
            for (int j = 0; j < TMO; j++) begin
                case (mode)
                    0:       lk[j] = (j >= lock_lat);
                    1:       lk[j] = 1'b0;
                    2:       lk[j] = (j >= lock_lat) && (j != lock_lat + 1000);
                    default: lk[j] = (j < 600) ? ($urandom_range(0, 9) != 0) : 1'b1;
                endcase
            end
            F = L0 + TMO; isdone = 0; run = 0;
            for (int j = 0; j < TMO; j++) begin
                run = lk[j] ? run + 1 : 0;
                if (run == STABLE) begin
                    F = L0 + j + 1; isdone = 1;
                    break;
                end
            end
            if (r_slot >= 0) R = asrt[r_slot] + 2;
            if (xs_slot >= 0) xs = asrt[xs_slot] + 1;
            for (int c = s + 1; c <= F && c <= R; c++) exp_busy[c] = 1'b1;
            for (int i = 0; i < 8; i++) begin
                for (int c = asrt[i]; c <= acc[i] && c <= R; c++) exp_mw[c] = 1'b1;
                for (int c = asrt[i]; c < acc[i] && c <= R; c++) wr_sched[c] = 1'b1;
                if (acc[i] <= R) push_ev(0, acc[i], adr[i], dat[i]);
            end
            for (int c = acc[7] + GAP + 1; c < L0 && c <= R; c++) exp_prst[c] = 1'b1;
            for (int c = s; c < L0 && c <= R; c++) lk_sched[c] = 1'($urandom_range(0, 1));
            for (int j = 0; j < TMO && L0 + j <= R && L0 + j < F; j++) lk_sched[L0 + j] = lk[j];
            if (F <= R) begin
                if (isdone != 0) model_freq = f;
                push_ev(isdone != 0 ? 1 : 2, F, 6'd0, {20'd0, model_freq});
            end
            endc = (R < MAXC - 1) ? R + 1 : F + 2;
        end
        for (int c = s + 1; c <= endc; c++) begin
            @(posedge clk); #1;
            start = (c == xs);
            if (c == xs) preset_idx = 6'($urandom_range(0, 37));
            rst = (c == R);
            if (c == R + 1) begin
                model_freq = '0;
                @(negedge clk);
                chk_reset_outputs();
            end
        end
    endtask

    initial begin
        #(20 * 95000);
        $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (stall[i]) stall[i] = 0;
        lock_lat = 120;
        go(0, 0, -1, -1);
        stall[3] = 5;
        lock_lat = 10;
        go(5, 0, -1, -1);
        stall[3] = 0;
        go(37, 1, -1, -1);
        go(38, 0, -1, -1);
        go(63, 0, -1, -1);
        stall[5] = 4;
        go(20, 0, 2, 5);
        stall[5] = 0;
        lock_lat = 0;
        go(12, 0, -1, -1);
        lock_lat = 50;
        go(7, 2, -1, -1);
        for (int n = 0; n < 5; n++) begin
            foreach (stall[i]) stall[i] = $urandom_range(0, 3);
            lock_lat = $urandom_range(0, 200);
            go($urandom_range(0, 45), ($urandom_range(0, 5) == 0) ? 1 : (($urandom_range(0, 1) == 0) ? 0 : 3), -1, -1);
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
